// File: rtl/detect_stats_pkg.sv
// Shared definitions for detect_stats: FSM state encoding and saturation helpers.
package detect_stats_pkg;

    localparam int DEF_CNT_W = 16;
    localparam int DEF_GAP_W = 8;
    localparam int DEF_DEPTH = 4;

    localparam logic [0:0] ST_WAIT_FIRST = 1'b0;
    localparam logic [0:0] ST_TRACK      = 1'b1;

    // All-ones value of a w-bit counter; callers cast it down to their own width.
    function automatic longint unsigned sat_max(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    localparam longint unsigned DEF_CNT_MAX = sat_max(DEF_CNT_W);
    localparam longint unsigned DEF_GAP_MAX = sat_max(DEF_GAP_W);

endpackage

// File: rtl/gap_fifo.sv
// Synchronous first-word-fall-through FIFO; head and level come straight from registers.
// A push into a full FIFO is taken only when a pop frees a slot in the same cycle.
module gap_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         data_in,
    output logic                     full,
    input  logic                     pop,
    output logic [WIDTH-1:0]         data_out,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full (MSBs differ) from empty (pointers equal).
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level    = wr_ptr_q - rd_ptr_q;
    assign data_out = mem_q[rd_ptr_q[AW-1:0]];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q[AW-1:0]] = data_in;
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: rtl/detect_stats.sv
// Detection statistics: saturating detection count plus inter-detection gaps queued in a FIFO.
// One-cycle latency from det_in to all outputs; gap samples drained via gap_valid/gap_ready.
module detect_stats
    import detect_stats_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int GAP_W = DEF_GAP_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     det_in,
    input  logic                     clr,
    output logic [CNT_W-1:0]         det_cnt,
    output logic [GAP_W-1:0]         gap_data,
    output logic                     gap_valid,
    input  logic                     gap_ready,
    output logic [$clog2(DEPTH):0]   gap_level,
    output logic                     ovf
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(sat_max(GAP_W));

    logic [0:0]       state_q, state_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0] det_cnt_q, det_cnt_d;
    logic             ovf_q, ovf_d;

    logic             fifo_push;
    logic             fifo_flush;
    logic             fifo_full;
    logic             fifo_empty;

    always_comb begin
        state_d    = state_q;
        gap_cnt_d  = gap_cnt_q;
        det_cnt_d  = det_cnt_q;
        ovf_d      = ovf_q;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        if (clr) begin
            state_d    = ST_WAIT_FIRST;
            gap_cnt_d  = '0;
            det_cnt_d  = '0;
            ovf_d      = 1'b0;
            fifo_flush = 1'b1;
        end else begin
            if (det_in && (det_cnt_q != CNT_MAX)) begin
                det_cnt_d = det_cnt_q + CNT_W'(1);
            end
            case (state_q)
                ST_WAIT_FIRST: begin
                    if (det_in) begin
                        gap_cnt_d = GAP_W'(1);
                        state_d   = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (det_in) begin
                        fifo_push = 1'b1;
                        gap_cnt_d = GAP_W'(1);
                        // A full FIFO always has a valid head, so gap_ready alone decides if a slot frees up.
                        if (fifo_full && !gap_ready) begin
                            ovf_d = 1'b1;
                        end
                    end else if (gap_cnt_q != GAP_MAX) begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    end
                end
                default: state_d = ST_WAIT_FIRST;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_WAIT_FIRST;
            gap_cnt_q <= '0;
            det_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            det_cnt_q <= det_cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    gap_fifo #(
        .WIDTH (GAP_W),
        .DEPTH (DEPTH)
    ) u_gap_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (fifo_flush),
        .push     (fifo_push),
        .data_in  (gap_cnt_q),
        .full     (fifo_full),
        .pop      (gap_ready),
        .data_out (gap_data),
        .empty    (fifo_empty),
        .level    (gap_level)
    );

    assign gap_valid = !fifo_empty;
    assign det_cnt   = det_cnt_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_detect_stats.sv
// Bench for detect_stats (CNT_W=4, GAP_W=8, DEPTH=4): directed scenarios plus randomized traffic vs. a reference model.
module tb_detect_stats;

    logic       clk = 1'b0;
    logic       rst;
    logic       det_in;
    logic       clr;
    logic [3:0] det_cnt;
    logic [7:0] gap_data;
    logic       gap_valid;
    logic       gap_ready;
    logic [2:0] gap_level;
    logic       ovf;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: detection edge numbers, gap = edge distance capped at 255.
    int      m_q[$];
    int      m_cnt;
    bit      m_ovf;
    bit      m_have;
    longint  m_last;
    longint  m_cyc = 0;

    detect_stats #(.CNT_W(4), .GAP_W(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .det_in    (det_in),
        .clr       (clr),
        .det_cnt   (det_cnt),
        .gap_data  (gap_data),
        .gap_valid (gap_valid),
        .gap_ready (gap_ready),
        .gap_level (gap_level),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        bit do_pop;
        bit was_full;
        longint d;
        m_cyc++;
        if (rst || clr) begin
            m_q.delete();
            m_cnt  = 0;
            m_ovf  = 1'b0;
            m_have = 1'b0;
            return;
        end
        do_pop   = gap_ready && (m_q.size() > 0);
        was_full = (m_q.size() == 4);
        if (do_pop) void'(m_q.pop_front());
        if (det_in) begin
            if (m_have) begin
                d = m_cyc - m_last;
                if (d > 255) d = 255;
                if (!was_full || do_pop) m_q.push_back(int'(d));
                else m_ovf = 1'b1;
            end
            if (m_cnt < 15) m_cnt++;
            m_last = m_cyc;
            m_have = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse();
        det_in = 1'b1;
        tick();
        det_in = 1'b0;
    endtask

    task automatic do_clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; det_in = 1'b1; tick();
        det_in = 1'b0; tick();
        rst = 1'b0;
        n_checks++; if (det_cnt !== 4'd0) $display("FAIL reset_cnt: got %0d expected 0", det_cnt); else n_pass++;
        n_checks++; if (gap_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", gap_valid); else n_pass++;
        n_checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %0b expected 0", ovf); else n_pass++;
        n_checks++; if (gap_level !== 3'd0) $display("FAIL reset_level: got %0d expected 0", gap_level); else n_pass++;
        n_checks++; if (gap_data !== 8'd0) $display("FAIL reset_data: got %0d expected 0", gap_data); else n_pass++;
        pulse();
        n_checks++; if (det_cnt !== 4'd1) $display("FAIL first_pulse_cnt: got %0d expected 1", det_cnt); else n_pass++;
        n_checks++; if (gap_level !== 3'd0) $display("FAIL first_pulse_level: got %0d expected 0", gap_level); else n_pass++;
    endtask

    task automatic test_gap_values();
        int exp_gap[3];
        exp_gap = '{1, 3, 10};
        do_clear();
        gap_ready = 1'b0;
        idle(9);
        pulse(); pulse(); idle(2); pulse(); idle(9); pulse();
        n_checks++; if (det_cnt !== 4'd4) $display("FAIL gap_cnt: got %0d expected 4", det_cnt); else n_pass++;
        n_checks++; if (gap_level !== 3'd3) $display("FAIL gap_level: got %0d expected 3", gap_level); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (gap_data !== 8'(exp_gap[i])) $display("FAIL gap_pop%0d: got %0d expected %0d", i, gap_data, exp_gap[i]);
            else n_pass++;
            gap_ready = 1'b1; tick(); gap_ready = 1'b0;
        end
        n_checks++; if (gap_valid !== 1'b0) $display("FAIL gap_drained: got %0b expected 0", gap_valid); else n_pass++;
    endtask

    task automatic test_saturation();
        do_clear();
        gap_ready = 1'b0;
        pulse(); idle(299); pulse();
        n_checks++; if (gap_data !== 8'd255) $display("FAIL gap_sat: got %0d expected 255", gap_data); else n_pass++;
        do_clear();
        for (int i = 0; i < 20; i++) pulse();
        n_checks++; if (det_cnt !== 4'd15) $display("FAIL cnt_sat: got %0d expected 15", det_cnt); else n_pass++;
    endtask

    task automatic test_overflow();
        do_clear();
        gap_ready = 1'b0;
        pulse();
        for (int g = 1; g <= 5; g++) begin idle(g - 1); pulse(); end
        n_checks++; if (gap_level !== 3'd4) $display("FAIL ovf_level: got %0d expected 4", gap_level); else n_pass++;
        n_checks++; if (ovf !== 1'b1) $display("FAIL ovf_set: got %0b expected 1", ovf); else n_pass++;
        for (int g = 1; g <= 4; g++) begin
            n_checks++;
            if (gap_data !== 8'(g)) $display("FAIL ovf_order%0d: got %0d expected %0d", g, gap_data, g); else n_pass++;
            gap_ready = 1'b1; tick(); gap_ready = 1'b0;
        end
        do_clear();
        pulse();
        for (int g = 1; g <= 4; g++) begin idle(g - 1); pulse(); end
        idle(4);
        det_in = 1'b1; gap_ready = 1'b1; tick();
        det_in = 1'b0; gap_ready = 1'b0;
        n_checks++; if (ovf !== 1'b0) $display("FAIL popfull_ovf: got %0b expected 0", ovf); else n_pass++;
        n_checks++; if (gap_level !== 3'd4) $display("FAIL popfull_level: got %0d expected 4", gap_level); else n_pass++;
        for (int g = 2; g <= 5; g++) begin
            n_checks++;
            if (gap_data !== 8'(g)) $display("FAIL popfull_order%0d: got %0d expected %0d", g, gap_data, g); else n_pass++;
            gap_ready = 1'b1; tick(); gap_ready = 1'b0;
        end
    endtask

    task automatic test_wrap();
        int pushes = 0;
        int pops = 0;
        int wait_left = 0;
        bit level_bad = 1'b0;
        do_clear();
        pulse();
        for (int c = 0; c < 400 && pushes < 20; c++) begin
            if (wait_left == 0) begin
                det_in = 1'b1;
                wait_left = $urandom_range(2, 4);
                pushes++;
            end else begin
                det_in = 1'b0;
            end
            wait_left--;
            gap_ready = c[0];
            if (gap_valid && gap_ready && m_q.size() > 0) begin
                pops++;
                n_checks++;
                if (gap_data !== 8'(m_q[0])) $display("FAIL wrap_order%0d: got %0d expected %0d", pops, gap_data, m_q[0]);
                else n_pass++;
            end
            tick();
            if (gap_level > 3'd4) level_bad = 1'b1;
        end
        det_in = 1'b0;
        gap_ready = 1'b1;
        for (int c = 0; c < 10 && m_q.size() > 0; c++) begin
            pops++;
            n_checks++;
            if (gap_data !== 8'(m_q[0])) $display("FAIL wrap_drain%0d: got %0d expected %0d", pops, gap_data, m_q[0]);
            else n_pass++;
            tick();
        end
        gap_ready = 1'b0;
        n_checks++; if (level_bad) $display("FAIL wrap_level: got above 4 expected at most 4"); else n_pass++;
        n_checks++; if (pops !== 20) $display("FAIL wrap_count: got %0d pops expected 20", pops); else n_pass++;
        n_checks++; if (ovf !== 1'b0) $display("FAIL wrap_ovf: got %0b expected 0", ovf); else n_pass++;
    endtask

    task automatic test_clear_mid_stream();
        do_clear();
        gap_ready = 1'b0;
        pulse(); pulse(); idle(1); pulse(); idle(2); pulse();
        n_checks++; if (gap_level !== 3'd3) $display("FAIL clr_pre_level: got %0d expected 3", gap_level); else n_pass++;
        clr = 1'b1; det_in = 1'b1; tick();
        clr = 1'b0; det_in = 1'b0;
        n_checks++; if (det_cnt !== 4'd0) $display("FAIL clr_cnt: got %0d expected 0", det_cnt); else n_pass++;
        n_checks++; if (gap_valid !== 1'b0) $display("FAIL clr_valid: got %0b expected 0", gap_valid); else n_pass++;
        n_checks++; if (gap_level !== 3'd0) $display("FAIL clr_level: got %0d expected 0", gap_level); else n_pass++;
        n_checks++; if (gap_data !== 8'd0) $display("FAIL clr_data: got %0d expected 0", gap_data); else n_pass++;
        n_checks++; if (ovf !== 1'b0) $display("FAIL clr_ovf: got %0b expected 0", ovf); else n_pass++;
        idle(3);
        pulse();
        n_checks++; if (det_cnt !== 4'd1) $display("FAIL clr_arm_cnt: got %0d expected 1", det_cnt); else n_pass++;
        n_checks++; if (gap_level !== 3'd0) $display("FAIL clr_arm_level: got %0d expected 0", gap_level); else n_pass++;
        idle(1); pulse();
        n_checks++; if (gap_data !== 8'd2) $display("FAIL clr_next_gap: got %0d expected 2", gap_data); else n_pass++;
    endtask

    task automatic test_random();
        int errs = 0;
        do_clear();
        for (int c = 0; c < 3000; c++) begin
            det_in    = ($urandom_range(0, 2) == 0);
            gap_ready = ($urandom_range(0, 3) == 0);
            clr       = ($urandom_range(0, 299) == 0);
            rst       = ($urandom_range(0, 699) == 0);
            tick();
            n_checks++;
            if (det_cnt !== 4'(m_cnt) || gap_level !== 3'(m_q.size()) || ovf !== m_ovf ||
                gap_valid !== (m_q.size() > 0) || (m_q.size() > 0 && gap_data !== 8'(m_q[0]))) begin
                if (errs < 10)
                    $display("FAIL rand_cycle%0d: got cnt=%0d lvl=%0d ovf=%0b vld=%0b dat=%0d expected cnt=%0d lvl=%0d ovf=%0b head=%0d",
                             c, det_cnt, gap_level, ovf, gap_valid, gap_data, m_cnt, m_q.size(), m_ovf,
                             (m_q.size() > 0) ? m_q[0] : 0);
                errs++;
            end else begin
                n_pass++;
            end
        end
        det_in = 1'b0; gap_ready = 1'b0; clr = 1'b0; rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; det_in = 1'b0; gap_ready = 1'b0;
        test_reset();
        test_gap_values();
        test_saturation();
        test_overflow();
        test_wrap();
        test_clear_mid_stream();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/detect_stats.md
# detect_stats

Downstream consumer of `seq_detect`: takes its single-bit `detector` output and produces detection statistics. It keeps a saturating total count of detections and measures the cycle gap between consecutive detections. Gaps are queued in a small first-word-fall-through FIFO. A host or a monitor block drains the FIFO over a valid/ready handshake.

## Interface
- `CNT_W`, default 16: width of total-detection counter.
- `GAP_W`, default 8: width of each gap sample; saturates at 2^GAP_W−1.
- `DEPTH`, default 4: gap FIFO entries; power of two, ≥2.
- `clk`  in  1  clock. One clock domain; everything is registered on its rising edge.
- `rst`  in  1  reset. Synchronous and active-high.
- `det_in`  in  1  detector pulse from `seq_detect`. Each high cycle counts as one detection; back-to-back highs are separate detections.
- `clr`  in  1  synchronous clear. Same effect as `rst`.
- `det_cnt`  out  CNT_W  total detections since reset/clear. Saturating.
- `gap_data`  out  GAP_W  FIFO head. Only meaningful while `gap_valid`=1.
- `gap_valid`  out  1  FIFO not empty.
- `gap_ready`  in  1  consumer accepts the head. A pop happens when `gap_valid & gap_ready`.
- `gap_level`  out  $clog2(DEPTH)+1  number of FIFO entries.
- `ovf`  out  1  sticky flag: a gap sample was dropped because the FIFO was full.

## Operation
- Priority: `rst` > `clr` > normal operation. In a cycle where `clr` is high, `det_in` is ignored.
- FSM `WAIT_FIRST` → `TRACK`:
  - `WAIT_FIRST`: a detection increments `det_cnt`, loads `gap_cnt` with 1, and moves to `TRACK`. No FIFO push.
  - `TRACK`, no detection: `gap_cnt` increments, saturating at 2^GAP_W−1.
  - `TRACK`, detection: push the current `gap_cnt`, reload `gap_cnt` with 1, increment `det_cnt`. Stay in `TRACK`.
  - `TRACK` is left only through `rst` or `clr`.
- Gap value is the distance in cycles between detection edges:
  - detections at edges k and k+1 → push 1
  - detections at edges k and k+3 → push 3
  - more than 255 cycles apart (GAP_W=8) → push 255
- `det_cnt` sticks at 2^CNT_W−1 once it reaches that value.
- FIFO push rules:
  - A push into a full FIFO is dropped and `ovf` is set.
  - If a pop happens in the same cycle as a push into a full FIFO, the push is accepted and `ovf` is not set.
  - A simultaneous push and pop on a non-empty FIFO leaves `gap_level` unchanged.
  - A pop on an empty FIFO is ignored.
- `ovf` clears only on `rst` or `clr`.
- Reset/clear values: `det_cnt`=0, `gap_valid`=0, `gap_data`=0 (all entries zeroed), `gap_level`=0, `ovf`=0, FSM=`WAIT_FIRST`, `gap_cnt`=0. Read and write pointers return to 0.

## Timing
- `det_in` is sampled at edge k. The `det_cnt` update, FIFO push, `gap_valid`, and `gap_level` all appear after edge k. Latency is 1 cycle.
- `gap_data`, `gap_valid`, and `gap_level` are driven straight from registers; there is no combinational path from `gap_ready`.
- Pop at edge k: the next entry appears on `gap_data` after edge k.
- `clr` or `rst` asserted mid-stream: the FIFO is flushed at that edge, and any pending gap sample is discarded.
- Pointer wrap-around: the DEPTH-aligned pointers use an extra MSB to tell full from empty. Data order must hold across the wrap.

## Structure
- Package `detect_stats_pkg` holds the FSM state encoding (`ST_WAIT_FIRST`, `ST_TRACK`) and the saturation-max constants derived from `CNT_W`/`GAP_W`.
- One sub-module, `gap_fifo`, a parameterised synchronous FIFO (`WIDTH`, `DEPTH`):
  - Ports: push/data_in/full, pop/data_out/empty, level, flush.
  - The top level holds the FSM, `gap_cnt`, `det_cnt`, and `ovf`.

## Test plan
All cases use a 10 ns clock and a single-cycle `det_in` pulse unless stated.
- **Reset:** `rst`=1 for 2 cycles with `det_in` toggling → `det_cnt`=0, `gap_valid`=0, `ovf`=0. Afterwards, the first pulse gives `det_cnt`=1 and `gap_level`=0.
- **Gap values:** pulses at cycles 10, 11, 14, 24, `gap_ready`=0 → `det_cnt`=4, `gap_level`=3. Popping then returns 1, 3, 10 in that order.
- **Saturation:** pulses 300 cycles apart with GAP_W=8 → gap 255. With CNT_W=4 and 20 pulses → `det_cnt`=15.
- **Overflow:** DEPTH=4, 6 pulses, `gap_ready`=0 → `gap_level`=4, `ovf`=1, FIFO holds the first 4 gaps. A repeat run with `gap_ready`=1 in the cycle the 5th gap is pushed into the full FIFO → push accepted, `ovf` stays 0.
- **Wrap-around:** continuous stream of 20 gaps with alternating `gap_ready` → read order matches push order, `gap_level` never exceeds 4.
- **Clear mid-stream:** `clr` in the same cycle as a pulse, with 3 entries queued → all outputs at reset values. The next pulse only arms the FSM: `det_cnt`=1, no push.
